// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the proc2 run controller and the HEX state display.
package proc_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        StHalt  = 2'd0,
        StRun   = 2'd1,
        StStep  = 2'd2,
        StBreak = 2'd3
    } run_state_e;

    // RUN and STEP are the only states in which the processor is clocked.
    function automatic logic is_active(input run_state_e s);
        return (s == StRun) || (s == StStep);
    endfunction

endpackage

// File: rtl/proc_run_ctrl_if.sv
// Control/status bundle between the board I/O, the proc2 core and the run controller.
interface proc_run_ctrl_if #(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned CNT_W = 16
);
    import proc_ctrl_pkg::*;

    logic                run_sw;
    logic                step_key;
    logic                bp_en;
    logic [PC_W-1:0]     bp_addr;
    logic [PC_W-1:0]     pc;
    logic                done;
    logic                tick;
    logic [STATE_W-1:0]  state;
    logic                at_break;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        output run_sw, step_key, bp_en, bp_addr, pc, done,
        input  tick, state, at_break, instr_count
    );

    modport slave (
        input  run_sw, step_key, bp_en, bp_addr, pc, done,
        output tick, state, at_break, instr_count
    );

endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, level debounce and rising-edge pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic pulse_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    // Any cycle where the synced key agrees with the level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Clock-enable scheduler for proc2: continuous run, single step and PC breakpoint,
// plus a retired-instruction counter.
module proc_run_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int unsigned DIV      = 50000000,
    parameter int unsigned DEBOUNCE = 500000,
    parameter int unsigned PC_W     = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    proc_run_ctrl_if.slave  bus
);

    localparam int unsigned PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    run_state_e       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             at_break_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  pc_w, bp_w;
    logic             step_pulse;
    logic             bp_hit;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_step_key (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .key_i   (bus.step_key),
        .pulse_o (step_pulse)
    );

    assign pc_w   = bus.pc;
    assign bp_w   = bus.bp_addr;
    assign bp_hit = bus.done && bus.bp_en && (pc_w == bp_w);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHalt: begin
                if (bus.run_sw) begin
                    state_d = StRun;
                end else if (step_pulse) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (bp_hit) begin
                    state_d = StBreak;
                end else if (!bus.run_sw) begin
                    state_d = StHalt;
                end
            end
            StStep: begin
                if (bp_hit) begin
                    state_d = StBreak;
                end else if (bus.done) begin
                    state_d = StHalt;
                end
            end
            StBreak: begin
                if (!bus.run_sw) begin
                    state_d = StHalt;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    // Prescaler only runs while staying in an active state, so it is 0 on entry
    // and a tick is never issued in the cycle after leaving RUN/STEP.
    always_comb begin
        pre_d  = '0;
        tick_d = 1'b0;
        if (is_active(state_q) && is_active(state_d)) begin
            pre_d  = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
            tick_d = (pre_q == PRE_MAX);
        end
        count_d = count_q;
        if (is_active(state_q) && bus.done) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StHalt;
            pre_q      <= '0;
            tick_q     <= 1'b0;
            at_break_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            at_break_q <= (state_d == StBreak);
            count_q    <= count_d;
        end
    end

    assign bus.tick        = tick_q;
    assign bus.state       = state_q;
    assign bus.at_break    = at_break_q;
    assign bus.instr_count = count_q;

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
Execution controller sitting between the board clock and the proc2 processor. It replaces free-running divided-clock operation with a single-clock-domain clock-enable (tick) scheduler. It supports three operating modes: continuous run at a programmable rate, instruction-granular single-step from a push-button, and halt-on-breakpoint against the processor PC. It also counts retired instructions for display on the HEX digits.

Parameters:
DIV, 50000000, Clock cycles between successive tick pulses while executing (>=2)
DEBOUNCE, 500000, Consecutive stable cycles required to accept a new step_key level (>=2)
PC_W, 16, Width of pc and bp_addr
CNT_W, 16, Width of instr_count

Ports:
Clock  input  1  System clock (50 MHz board clock); single clock domain
Reset  input  1  Synchronous, active-high reset
run_sw  input  1  Level: 1 = continuous run requested (slide switch)
step_key  input  1  Raw, asynchronous, active-high step button (already inverted from KEY)
bp_en  input  1  Breakpoint compare enable
bp_addr  input  PC_W  Breakpoint address
pc  input  PC_W  Processor PC, valid whenever done is high
done  input  1  Processor instruction-complete strobe, one Clock cycle wide
tick  output  1  One-cycle clock-enable pulse to the processor
state  output  2  Current FSM state (encoding in package)
at_break  output  1  High while in BREAK
instr_count  output  CNT_W  Instructions retired since reset

Behaviour:
- Reset (synchronous, active-high) sets: state=HALT, tick=0, at_break=0, instr_count=0, prescaler=0, synchroniser/debounce registers=0, debounced level=0.
- Reset has priority over all other inputs. A reset asserted mid-operation aborts on the next edge; no further tick is issued.
- States: HALT=0, RUN=1, STEP=2, BREAK=3.
- Prescaler:
  - Counts 0..DIV-1 only in RUN or STEP; held at 0 in HALT and BREAK.
  - tick=1 for exactly the cycle in which the prescaler equals DIV-1 (registered output).
  - Result: the first tick comes DIV cycles after entering RUN/STEP.
- Step input path:
  - 2-FF synchroniser, then debounce counter.
  - Debounced level updates only after DEBOUNCE consecutive cycles of a synced value that differs from the current level. Any mismatch resets the counter.
  - step_pulse = one-cycle pulse on a 0->1 edge of the debounced level.
  - A key held through reset produces one pulse DEBOUNCE(+2) cycles after reset release.
- Transitions, evaluated each cycle in priority order:
  - HALT:
    - run_sw=1 -> RUN.
    - else step_pulse -> STEP.
    - If both occur in the same cycle, RUN wins and the pulse is discarded.
  - RUN:
    - done=1 with bp_en=1 and pc==bp_addr -> BREAK.
    - else run_sw=0 -> HALT.
    - A done seen in the same cycle as run_sw falling is still counted.
  - STEP:
    - done=1 with bp_en=1 and pc==bp_addr -> BREAK.
    - else done=1 -> HALT.
    - run_sw is ignored in STEP, so the in-flight instruction always completes.
  - BREAK:
    - Stays in BREAK while run_sw=1.
    - run_sw=0 -> HALT, so resume requires toggling the switch.
- step_pulse is ignored in RUN, STEP and BREAK.
- instr_count:
  - Increments by 1 on every cycle with done=1 while in RUN or STEP, including the cycle that causes BREAK.
  - Wraps modulo 2^CNT_W.
  - done outside RUN/STEP is ignored.
- Tick timing on exit: no tick is issued in the cycle after leaving RUN/STEP. A tick already registered in the exit cycle is allowed.
- at_break = (state==BREAK), registered with state.

Decomposition:
- Package proc_ctrl_pkg holds: the state encoding constants (HALT/RUN/STEP/BREAK, 2-bit) and the state width constant, shared with the HEX display mux that shows state.
- One sub-module, key_debounce, contains the synchroniser, debounce counter and rising-edge pulse, parameterised by DEBOUNCE. It is reused for future KEY inputs.

Test Plan:
- Bench parameters for all scenarios: DIV=4, DEBOUNCE=3.
- Reset then run: after reset, set run_sw=1 -> state=RUN next cycle; tick pulses every 4 cycles, first tick 4 cycles after entry; instr_count=0.
- Run counting and exit: in RUN, drive done for 5 ticks -> instr_count=5. Drop run_sw -> state=HALT, tick stays 0 afterwards.
- Step, clean press: step_key held high for 10 cycles in HALT -> exactly one STEP entry. Ticks until done=1 with pc=0x0003 (bp_en=0) -> HALT, instr_count+1. A bounce shorter than 3 cycles produces no step.
- Breakpoint: bp_en=1, bp_addr=0x0007, RUN; done with pc=0x0006 -> stay RUN. done with pc=0x0007 -> BREAK, at_break=1, ticks stop, count incremented. With run_sw still 1 -> stays BREAK; run_sw=0 -> HALT.
- Simultaneous events in HALT: run_sw rising in the same cycle as step_pulse -> RUN, no STEP.
- Counter wrap: with CNT_W=4, 17 done pulses -> instr_count=1.
- Reset mid-operation: Reset asserted while in STEP with the prescaler at 2 -> next cycle state=HALT, tick=0, instr_count=0.
